processor_return_stack: RTL and testbench

PROCESSOR_RETURN_STACK -- requirements
Module: processor_return_stack

---
 rtl/processor_return_stack_if.sv | 32 +++
 rtl/processor_return_stack.sv | 119 +++++++++++
 tb/tb_processor_return_stack.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/processor_return_stack_if.sv
// Bus bundle for processor_return_stack.
//   master : pipeline/control side; drives the stall, call/return requests and clear_errors,
//            and observes the popped address, status and sticky flags.
//   slave  : the return stack itself.
// Signal names match the block's port list. clock and reset stay plain module ports.
interface processor_return_stack_if #(
  parameter int ADDR_SIZE  = 18,
  parameter int DEPTH_LOG2 = 4
);
  logic                  no_operation;
  logic                  push_valid;
  logic [ADDR_SIZE-1:0]  push_addr;
  logic                  pop_request;
  logic                  clear_errors;
  logic [ADDR_SIZE-1:0]  ip_to_return;
  logic                  return_performed;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   depth_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output no_operation, push_valid, push_addr, pop_request, clear_errors,
    input  ip_to_return, return_performed, empty, full, depth_count, overflow, underflow
  );

  modport slave (
    input  no_operation, push_valid, push_addr, pop_request, clear_errors,
    output ip_to_return, return_performed, empty, full, depth_count, overflow, underflow
  );
endinterface

// File: rtl/processor_return_stack.sv
// processor_return_stack: hardware call/return address stack.
//   clock        : sole clock, rising edge.
//   reset        : asynchronous, active-low; clears pointer, count, pulse, output address and flags.
//   bus (slave)  : no_operation, push_valid, push_addr, pop_request, clear_errors in;
//                  ip_to_return, return_performed, empty, full, depth_count, overflow, underflow out.
// Optional feature: define CALL_STACK_WRAP_EN so that a push onto a full stack overwrites the
// oldest entry. Without it, that push is dropped. Either way the overflow flag is set.
module processor_return_stack #(
  parameter int ADDR_SIZE  = 18,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic clock,
  input  logic reset,
  processor_return_stack_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  // Return addresses. The array is not reset; count and top pointer define the valid entries.
  logic [ADDR_SIZE-1:0]  mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] top_q, top_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]  ip_q, ip_d;
  logic                  ret_q, ret_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;

  logic do_push, do_pop, is_empty, is_full, pop_ok, pop_udf, push_ovf;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_FULL);
  assign do_push  = bus.push_valid  & ~bus.no_operation;
  assign do_pop   = bus.pop_request & ~bus.no_operation;
  assign pop_ok   = do_pop & ~is_empty;
  assign pop_udf  = do_pop & is_empty;
  // A push paired with a successful pop replaces the top entry, so it cannot overflow.
  assign push_ovf = do_push & is_full & ~pop_ok;

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    ip_d   = ip_q;
    ret_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = top_q + PTR_ONE;

    if (pop_ok && do_push) begin
      // Swap: return the old top and overwrite it in place. Count is unchanged.
      ip_d   = mem_q[top_q];
      ret_d  = 1'b1;
      wr_en  = 1'b1;
      wr_idx = top_q;
    end else if (pop_ok) begin
      ip_d  = mem_q[top_q];
      ret_d = 1'b1;
      top_d = top_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end else if (do_push) begin
      if (!is_full) begin
        wr_en = 1'b1;
        top_d = top_q + PTR_ONE;
        cnt_d = cnt_q + CNT_ONE;
      end else begin
`ifdef CALL_STACK_WRAP_EN
        // When the stack is full, top+1 is the oldest slot. Overwrite it and keep the count at DEPTH.
        wr_en = 1'b1;
        top_d = top_q + PTR_ONE;
`else
        // Drop the push and leave the stack unchanged.
        wr_en = 1'b0;
`endif
      end
    end

    // Sticky flags. A new error event in the same cycle wins over clear_errors.
    ovf_d = bus.clear_errors ? 1'b0 : ovf_q;
    udf_d = bus.clear_errors ? 1'b0 : udf_q;
    if (push_ovf) ovf_d = 1'b1;
    if (pop_udf)  udf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      top_q <= '0;
      cnt_q <= '0;
      ip_q  <= '0;
      ret_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ip_q  <= ip_d;
      ret_q <= ret_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // A write can land in the same clock as an asynchronous reset assertion. The valid-entry
  // bookkeeping is cleared by the reset, so any such write is harmless.
  always_ff @(posedge clock) begin
    if (wr_en && reset) mem_q[wr_idx] <= bus.push_addr;
  end

  assign bus.ip_to_return     = ip_q;
  assign bus.return_performed = ret_q;
  assign bus.empty            = is_empty;
  assign bus.full             = is_full;
  assign bus.depth_count      = cnt_q;
  assign bus.overflow         = ovf_q;
  assign bus.underflow        = udf_q;
endmodule

// File: tb/tb_processor_return_stack.sv
module tb_processor_return_stack;
  localparam int AW = 18;
  localparam int DL = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  processor_return_stack_if #(.ADDR_SIZE(AW), .DEPTH_LOG2(DL)) bus ();

  processor_return_stack #(.ADDR_SIZE(AW), .DEPTH_LOG2(DL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          nop;
    logic          push;
    logic [AW-1:0] addr;
    logic          pop;
    logic          clr;
    logic          e_ret;
    logic [AW-1:0] e_ip;
    int            e_cnt;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic nop, push, input logic [AW-1:0] addr, input logic pop, clr,
                     input logic e_ret, input logic [AW-1:0] e_ip, input int e_cnt,
                     input logic e_ovf, e_udf);
    vec_t v;
    v.nop = nop; v.push = push; v.addr = addr; v.pop = pop; v.clr = clr;
    v.e_ret = e_ret; v.e_ip = e_ip; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ret, input logic [AW-1:0] e_ip,
                         input int e_cnt, input logic e_ovf, input logic e_udf);
    chk({tag, ".ret"},   32'(bus.return_performed), 32'(e_ret));
    chk({tag, ".ip"},    32'(bus.ip_to_return),     32'(e_ip));
    chk({tag, ".cnt"},   32'(bus.depth_count),      32'(e_cnt));
    chk({tag, ".empty"}, 32'(bus.empty),            32'(e_cnt == 0));
    chk({tag, ".full"},  32'(bus.full),             32'(e_cnt == 16));
    chk({tag, ".ovf"},   32'(bus.overflow),         32'(e_ovf));
    chk({tag, ".udf"},   32'(bus.underflow),        32'(e_udf));
  endtask

  task automatic drive(input logic nop, push, input logic [AW-1:0] addr, input logic pop, clr);
    bus.no_operation = nop; bus.push_valid = push; bus.push_addr = addr;
    bus.pop_request = pop;  bus.clear_errors = clr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, '0, 0, 0);
    step();
    step();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    drive(0, 0, '0, 0, 0);
    step();
    step();
    chk_all("reset", 0, '0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    //  nop push addr     pop clr | ret ip       cnt ovf udf
    add(0, 1, 18'h00100, 0, 0,   0, 18'h0,     1, 0, 0);
    add(0, 1, 18'h00200, 0, 0,   0, 18'h0,     2, 0, 0);
    add(0, 0, 18'h0,     1, 0,   1, 18'h00200, 1, 0, 0);
    add(0, 0, 18'h0,     0, 0,   0, 18'h00200, 1, 0, 0);
    add(0, 0, 18'h0,     1, 0,   1, 18'h00100, 0, 0, 0);
    add(0, 0, 18'h0,     1, 0,   0, 18'h00100, 0, 0, 1);
    add(0, 0, 18'h0,     0, 1,   0, 18'h00100, 0, 0, 0);
    add(0, 1, 18'h00005, 0, 0,   0, 18'h00100, 1, 0, 0);
    add(0, 1, 18'h00009, 1, 0,   1, 18'h00005, 1, 0, 0);
    add(0, 0, 18'h0,     1, 0,   1, 18'h00009, 0, 0, 0);
    add(0, 1, 18'h00033, 1, 0,   0, 18'h00009, 1, 0, 1);
    add(0, 0, 18'h0,     1, 1,   1, 18'h00033, 0, 0, 0);
    add(0, 0, 18'h0,     1, 1,   0, 18'h00033, 0, 0, 1);
    add(0, 0, 18'h0,     0, 1,   0, 18'h00033, 0, 0, 0);
    add(1, 1, 18'h00044, 1, 0,   0, 18'h00033, 0, 0, 0);
    add(0, 1, 18'h00044, 0, 0,   0, 18'h00033, 1, 0, 0);
    add(1, 1, 18'h00077, 1, 0,   0, 18'h00033, 1, 0, 0);
    add(1, 1, 18'h00077, 1, 0,   0, 18'h00033, 1, 0, 0);
    add(1, 1, 18'h00077, 1, 0,   0, 18'h00033, 1, 0, 0);
    add(0, 0, 18'h0,     1, 0,   1, 18'h00044, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].nop, vecs[i].push, vecs[i].addr, vecs[i].pop, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_ret, vecs[i].e_ip, vecs[i].e_cnt,
              vecs[i].e_ovf, vecs[i].e_udf);
    end
    drive(0, 0, '0, 0, 0);

    // Pop on empty right after reset, then clear the error.
    do_reset();
    drive(0, 0, '0, 1, 0);
    step();
    chk_all("udf_after_reset", 0, '0, 0, 0, 1);
    drive(0, 0, '0, 0, 1);
    step();
    chk_all("udf_clear", 0, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 0);

    // Fill past capacity, then drain.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(0, 1, AW'(i), 0, 0);
      step();
    end
    drive(0, 0, '0, 0, 0);
    chk_all("overfill", 0, '0, 16, 1, 0);
    for (int k = 0; k < 16; k++) begin
      int exp_v;
`ifdef CALL_STACK_WRAP_EN
      exp_v = 17 - k;
`else
      exp_v = 16 - k;
`endif
      drive(0, 0, '0, 1, (k == 0));
      step();
      chk($sformatf("drain%0d.ret", k), 32'(bus.return_performed), 32'd1);
      chk($sformatf("drain%0d.ip", k),  32'(bus.ip_to_return),     32'(exp_v));
      chk($sformatf("drain%0d.cnt", k), 32'(bus.depth_count),      32'(15 - k));
    end
    drive(0, 0, '0, 0, 0);
    step();
    chk("drain.empty", 32'(bus.empty), 32'd1);
    chk("drain.ovf",   32'(bus.overflow), 32'd0);

    // Asynchronous reset between edges while a pop pulse is pending.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, AW'(18'h00a00 + i), 0, 0);
      step();
    end
    drive(0, 0, '0, 1, 0);
    step();
    chk("pre_rst.ret", 32'(bus.return_performed), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 0, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 0);
    step();
    @(negedge clock);
    reset = 1'b1;
    step();
    chk_all("post_rst1", 0, '0, 0, 0, 0);
    step();
    chk_all("post_rst2", 0, '0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
